shift_pipe: RTL

Parametrised, pipelined barrel shifter for the CPU execute stage. It supersedes the single-cycle 32-bit shift unit and adds configurable data width, configurable pipeline depth, and rotate operations. A valid/ready handshake and a pass-through tag let the issue logic stall it or flush it like any other multi-cycle functional unit.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_stage.sv | 81 ++++++++
 rtl/shift_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared op codes and the level-to-stage partitioning used by the pipelined shifter.
package shift_pkg;

  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;

  typedef struct packed {
    int unsigned first;
    int unsigned last;
  } level_range_t;

  // Level i lives in stage floor(i*stages/levels); invert that to get each stage's span.
  function automatic level_range_t stage_levels(input int unsigned stage,
                                                input int unsigned stages,
                                                input int unsigned levels);
    level_range_t r;
    r.first = (stage * levels + stages - 1) / stages;
    r.last  = ((stage + 1) * levels + stages - 1) / stages - 1;
    return r;
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One register stage of the barrel shifter: levels FIRST_LVL..LAST_LVL, then a
// skid-free pipeline register with local valid/ready.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned FIRST_LVL = 0,
  parameter int unsigned LAST_LVL  = 0,
  localparam int unsigned SHAMT_W  = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               up_valid,
  output logic               ready_c,
  input  logic               down_ready,
  input  logic [DATA_W-1:0]  up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  logic [3:0]         up_op,
  input  logic               up_sign,
  input  logic               up_illegal,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               valid,
  output logic [DATA_W-1:0]  data,
  output logic [SHAMT_W-1:0] shamt,
  output logic [3:0]         op,
  output logic               sign,
  output logic               illegal,
  output logic [TAG_W-1:0]   tag
);

  localparam logic [DATA_W-1:0] ONES = '1;

  logic [DATA_W-1:0] shifted;

  assign ready_c = !valid || down_ready;

  // Each level moves the operand by 2^i; SRA refills from the captured sign bit.
  always_comb begin
    shifted = up_data;
    for (int i = int'(FIRST_LVL); i <= int'(LAST_LVL); i++) begin
      if (up_shamt[i]) begin
        case (up_op)
          OP_SLL:  shifted = shifted << (1 << i);
          OP_SRL:  shifted = shifted >> (1 << i);
          OP_SRA:  shifted = (shifted >> (1 << i)) | (up_sign ? ~(ONES >> (1 << i)) : '0);
          OP_ROL:  shifted = (shifted << (1 << i)) | (shifted >> (DATA_W - (1 << i)));
          OP_ROR:  shifted = (shifted >> (1 << i)) | (shifted << (DATA_W - (1 << i)));
          default: shifted = shifted;
        endcase
      end
    end
  end

  // Payload only moves on a real load so a stalled result stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      data    <= '0;
      shamt   <= '0;
      op      <= '0;
      sign    <= 1'b0;
      illegal <= 1'b0;
      tag     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready_c) begin
      valid <= up_valid;
      if (up_valid) begin
        data    <= shifted;
        shamt   <= up_shamt;
        op      <= up_op;
        sign    <= up_sign;
        illegal <= up_illegal;
        tag     <= up_tag;
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshake, flush and a
// pass-through tag; STAGES copies of shift_stage split the log levels.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        ALU_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal
);

  localparam int unsigned SHAMT_W = $clog2(DATA_W);

  logic               valid_a   [STAGES+1];
  logic [DATA_W-1:0]  data_a    [STAGES+1];
  logic [SHAMT_W-1:0] shamt_a   [STAGES+1];
  logic [3:0]         op_a      [STAGES+1];
  logic               sign_a    [STAGES+1];
  logic               illegal_a [STAGES+1];
  logic [TAG_W-1:0]   tag_a     [STAGES+1];
  logic               legal;
  logic               unused_bits;

  // Illegal codes enter as zero data so every level leaves them at zero.
  assign legal        = is_shift_op(ALU_op);
  assign valid_a[0]   = in_valid;
  assign data_a[0]    = legal ? A : '0;
  assign shamt_a[0]   = B[SHAMT_W-1:0];
  assign op_a[0]      = ALU_op;
  assign sign_a[0]    = legal & A[DATA_W-1];
  assign illegal_a[0] = !legal;
  assign tag_a[0]     = in_tag;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam level_range_t LR = stage_levels(k, STAGES, SHAMT_W);
    logic rdy_c;
    logic down_rdy;

    if (k == STAGES - 1) begin : g_tail
      assign down_rdy = out_ready;
    end else begin : g_body
      assign down_rdy = g_stage[k+1].rdy_c;
    end

    shift_stage #(
      .DATA_W   (DATA_W),
      .TAG_W    (TAG_W),
      .FIRST_LVL(LR.first),
      .LAST_LVL (LR.last)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .up_valid  (valid_a[k]),
      .ready_c   (rdy_c),
      .down_ready(down_rdy),
      .up_data   (data_a[k]),
      .up_shamt  (shamt_a[k]),
      .up_op     (op_a[k]),
      .up_sign   (sign_a[k]),
      .up_illegal(illegal_a[k]),
      .up_tag    (tag_a[k]),
      .valid     (valid_a[k+1]),
      .data      (data_a[k+1]),
      .shamt     (shamt_a[k+1]),
      .op        (op_a[k+1]),
      .sign      (sign_a[k+1]),
      .illegal   (illegal_a[k+1]),
      .tag       (tag_a[k+1])
    );
  end

  assign in_ready    = g_stage[0].rdy_c;
  assign out_valid   = valid_a[STAGES];
  assign out         = data_a[STAGES];
  assign out_tag     = tag_a[STAGES];
  assign out_illegal = illegal_a[STAGES];

  // Upper B bits and the last stage's control fields have no consumer.
  assign unused_bits = ^{B[DATA_W-1:SHAMT_W], shamt_a[STAGES], op_a[STAGES], sign_a[STAGES]};

endmodule
